// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and small helpers for the memory arbiter.
//   Port indices: EXT=0, DMEM=1, IMEM=2.
//   Priority modes: round-robin=0, fixed priority with aging=1.
//   next_port   : cyclic successor of a port index (mod 3).
//   gnt_to_port : encode a one-hot 3-bit grant into a port index.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_PORT_EXT   = 0;
    localparam int unsigned MEM_ARB_PORT_DMEM  = 1;
    localparam int unsigned MEM_ARB_PORT_IMEM  = 2;
    localparam int unsigned MEM_ARB_NPORTS     = 3;

    localparam int unsigned MEM_ARB_PRIO_RR    = 0;
    localparam int unsigned MEM_ARB_PRIO_FIXED = 1;

    // Width of the per-port aging counters (MAX_WAIT up to 15).
    localparam int unsigned MEM_ARB_WAIT_W     = 4;

    // Successor of a port index in the rotation EXT -> DMEM -> IMEM -> EXT.
    function automatic logic [1:0] next_port(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // One-hot grant to port index; zero grant maps to EXT (caller qualifies).
    function automatic logic [1:0] gnt_to_port(input logic [2:0] gnt);
        if (gnt[MEM_ARB_PORT_DMEM]) return 2'(MEM_ARB_PORT_DMEM);
        if (gnt[MEM_ARB_PORT_IMEM]) return 2'(MEM_ARB_PORT_IMEM);
        return 2'(MEM_ARB_PORT_EXT);
    endfunction

endpackage

// File: rtl/arb_pick3.sv
// arb_pick3: combinational 3-way one-hot picker.
//   req   : request vector (bit index = port index)
//   start : port searched first; search continues start+1, start+2 (mod 3)
//   aged  : aged mask; if any aged port requests, only aged ports compete
//   gnt   : one-hot grant (zero when no request)
module arb_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start,
    input  logic [2:0] aged,
    output logic [2:0] gnt
);

    logic [2:0] aged_req;
    logic [2:0] cand;
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    // Aged requesters form a higher class; rotate search inside the winning class.
    always_comb begin
        gnt      = 3'b000;
        aged_req = req & aged;
        cand     = (|aged_req) ? aged_req : req;
        p0       = (start == 2'd3) ? 2'd0 : start;
        p1       = next_port(p0);
        p2       = next_port(p1);
        if (cand[p0]) begin
            gnt[p0] = 1'b1;
        end else if (cand[p1]) begin
            gnt[p1] = 1'b1;
        end else if (cand[p2]) begin
            gnt[p2] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between EXT (port 0),
// DMEM (port 1) and IMEM (port 2, read-only). One access per cycle; read data
// returns one cycle after the grant with rvalid on the owning port.
//   Parameters : ADDR_W, DATA_W, PRIO_MODE (0 round-robin, 1 fixed+aging), MAX_WAIT
//   Requesters : i_<p>_req/addr (all), i_<p>_we/wdata/mask (EXT, DMEM)
//   Grants     : o_<p>_gnt combinational, at most one high, zero during reset
//   Read return: o_<p>_rvalid registered, o_rdata = i_ram_rdata
//   RAM side   : o_ram_addr/wdata/we/mask, i_ram_rdata (1-cycle latency)
//   Optional   : MEM_ARB_PERF_EN adds o_conflict_cnt and o_imem_wait_cnt
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_ext_req,
    input  logic [ADDR_W-1:0]     i_ext_addr,
    input  logic                  i_ext_we,
    input  logic [DATA_W-1:0]     i_ext_wdata,
    input  logic [DATA_W/8-1:0]   i_ext_mask,

    input  logic                  i_dmem_req,
    input  logic [ADDR_W-1:0]     i_dmem_addr,
    input  logic                  i_dmem_we,
    input  logic [DATA_W-1:0]     i_dmem_wdata,
    input  logic [DATA_W/8-1:0]   i_dmem_mask,

    input  logic                  i_imem_req,
    input  logic [ADDR_W-1:0]     i_imem_addr,

    output logic                  o_ext_gnt,
    output logic                  o_dmem_gnt,
    output logic                  o_imem_gnt,
    output logic                  o_ext_rvalid,
    output logic                  o_dmem_rvalid,
    output logic                  o_imem_rvalid,
    output logic [DATA_W-1:0]     o_rdata,

    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    output logic                  o_ram_we,
    output logic [DATA_W/8-1:0]   o_ram_mask,
    input  logic [DATA_W-1:0]     i_ram_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           o_conflict_cnt,
    output logic [31:0]           o_imem_wait_cnt
`endif
);

    localparam int unsigned             MASK_W     = DATA_W / 8;
    localparam logic [MEM_ARB_WAIT_W-1:0] MAX_WAIT_C = MEM_ARB_WAIT_W'(MAX_WAIT);

    logic [2:0]                req;
    logic [2:0]                pick_gnt;
    logic [2:0]                gnt;
    logic [2:0]                aged;
    logic [2:0]                rd_gnt;
    logic [2:0]                rvalid_q;
    logic [1:0]                last_gnt;
    logic [1:0]                start;
    logic [MEM_ARB_WAIT_W-1:0] wait_cnt [MEM_ARB_NPORTS];

    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [MASK_W-1:0]         mask_q;

    assign req = {i_imem_req, i_dmem_req, i_ext_req};

    // Mode selection: rotating start for round-robin, fixed EXT-first with aging otherwise.
    always_comb begin
        start = 2'(MEM_ARB_PORT_EXT);
        aged  = 3'b000;
        if (PRIO_MODE == MEM_ARB_PRIO_FIXED) begin
            for (int i = 0; i < int'(MEM_ARB_NPORTS); i++) begin
                aged[i] = (wait_cnt[i] == MAX_WAIT_C);
            end
        end else begin
            start = next_port(last_gnt);
        end
    end

    arb_pick3 u_pick (
        .req   (req),
        .start (start),
        .aged  (aged),
        .gnt   (pick_gnt)
    );

    // Grants are suppressed while reset is asserted, even though they are combinational.
    assign gnt        = rst_n ? pick_gnt : 3'b000;
    assign o_ext_gnt  = gnt[MEM_ARB_PORT_EXT];
    assign o_dmem_gnt = gnt[MEM_ARB_PORT_DMEM];
    assign o_imem_gnt = gnt[MEM_ARB_PORT_IMEM];

    // Only reads produce a return beat; IMEM never writes.
    assign rd_gnt = gnt & {1'b1, ~i_dmem_we, ~i_ext_we};

    // RAM request mux; with no grant the address/data hold their last driven value.
    always_comb begin
        o_ram_addr  = addr_q;
        o_ram_wdata = wdata_q;
        o_ram_mask  = mask_q;
        o_ram_we    = 1'b0;
        if (gnt[MEM_ARB_PORT_EXT]) begin
            o_ram_addr  = i_ext_addr;
            o_ram_wdata = i_ext_wdata;
            o_ram_we    = i_ext_we;
            o_ram_mask  = i_ext_we ? i_ext_mask : '1;
        end else if (gnt[MEM_ARB_PORT_DMEM]) begin
            o_ram_addr  = i_dmem_addr;
            o_ram_wdata = i_dmem_wdata;
            o_ram_we    = i_dmem_we;
            o_ram_mask  = i_dmem_we ? i_dmem_mask : '1;
        end else if (gnt[MEM_ARB_PORT_IMEM]) begin
            o_ram_addr  = i_imem_addr;
            o_ram_mask  = '1;
        end
    end

    // Hold registers for the idle RAM bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (|gnt) begin
            addr_q  <= o_ram_addr;
            wdata_q <= o_ram_wdata;
            mask_q  <= o_ram_mask;
        end
    end

    // Owner tag of the in-flight read; async reset drops a pending return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 3'b000;
        end else begin
            rvalid_q <= rd_gnt;
        end
    end

    assign o_ext_rvalid  = rvalid_q[MEM_ARB_PORT_EXT];
    assign o_dmem_rvalid = rvalid_q[MEM_ARB_PORT_DMEM];
    assign o_imem_rvalid = rvalid_q[MEM_ARB_PORT_IMEM];
    assign o_rdata       = i_ram_rdata;

    // Round-robin pointer; reset to IMEM so EXT is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 2'(MEM_ARB_PORT_IMEM);
        end else if (|gnt) begin
            last_gnt <= gnt_to_port(gnt);
        end
    end

    // Per-port aging counters: count refused cycles, saturate, clear on grant or drop.
    for (genvar p = 0; p < int'(MEM_ARB_NPORTS); p++) begin : g_wait
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_cnt[p] <= '0;
            end else if (!req[p] || gnt[p]) begin
                wait_cnt[p] <= '0;
            end else if (wait_cnt[p] != MAX_WAIT_C) begin
                wait_cnt[p] <= wait_cnt[p] + MEM_ARB_WAIT_W'(1);
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;

    assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    // Contention and fetch-stall counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_conflict_cnt  <= '0;
            o_imem_wait_cnt <= '0;
        end else begin
            if (conflict) begin
                o_conflict_cnt <= o_conflict_cnt + 32'd1;
            end
            if (i_imem_req && !gnt[MEM_ARB_PORT_IMEM]) begin
                o_imem_wait_cnt <= o_imem_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// A round-robin instance drives a behavioural RAM; a fixed-priority instance
// (MAX_WAIT=4) shares the request stimulus and is checked on its grants.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic              ext_req, dmem_req, imem_req;
    logic [ADDR_W-1:0] ext_addr, dmem_addr, imem_addr;
    logic              ext_we, dmem_we;
    logic [DATA_W-1:0] ext_wdata, dmem_wdata;
    logic [MASK_W-1:0] ext_mask, dmem_mask;

    logic              rr_ext_gnt, rr_dmem_gnt, rr_imem_gnt;
    logic              rr_ext_rv, rr_dmem_rv, rr_imem_rv;
    logic [DATA_W-1:0] rr_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [MASK_W-1:0] ram_mask;
    logic [DATA_W-1:0] ram_rdata;

    logic              fx_ext_gnt, fx_dmem_gnt, fx_imem_gnt;
    logic              fx_ext_rv, fx_dmem_rv, fx_imem_rv;
    logic [DATA_W-1:0] fx_rdata;
    logic [ADDR_W-1:0] fx_ram_addr;
    logic [DATA_W-1:0] fx_ram_wdata;
    logic              fx_ram_we;
    logic [MASK_W-1:0] fx_ram_mask;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] rr_conflict_cnt, rr_imem_wait_cnt;
    logic [31:0] fx_conflict_cnt, fx_imem_wait_cnt;
    logic [31:0] c0, w0;
`endif

    wire [2:0] rr_gnt = {rr_imem_gnt, rr_dmem_gnt, rr_ext_gnt};
    wire [2:0] rr_rv  = {rr_imem_rv, rr_dmem_rv, rr_ext_rv};
    wire [2:0] fx_gnt = {fx_imem_gnt, fx_dmem_gnt, fx_ext_gnt};
    wire [2:0] fx_rv  = {fx_imem_rv, fx_dmem_rv, fx_ext_rv};

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0), .MAX_WAIT(4)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ext_req     (ext_req),
        .i_ext_addr    (ext_addr),
        .i_ext_we      (ext_we),
        .i_ext_wdata   (ext_wdata),
        .i_ext_mask    (ext_mask),
        .i_dmem_req    (dmem_req),
        .i_dmem_addr   (dmem_addr),
        .i_dmem_we     (dmem_we),
        .i_dmem_wdata  (dmem_wdata),
        .i_dmem_mask   (dmem_mask),
        .i_imem_req    (imem_req),
        .i_imem_addr   (imem_addr),
        .o_ext_gnt     (rr_ext_gnt),
        .o_dmem_gnt    (rr_dmem_gnt),
        .o_imem_gnt    (rr_imem_gnt),
        .o_ext_rvalid  (rr_ext_rv),
        .o_dmem_rvalid (rr_dmem_rv),
        .o_imem_rvalid (rr_imem_rv),
        .o_rdata       (rr_rdata),
        .o_ram_addr    (ram_addr),
        .o_ram_wdata   (ram_wdata),
        .o_ram_we      (ram_we),
        .o_ram_mask    (ram_mask),
        .i_ram_rdata   (ram_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .o_conflict_cnt  (rr_conflict_cnt),
        .o_imem_wait_cnt (rr_imem_wait_cnt)
`endif
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1), .MAX_WAIT(4)) u_fx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ext_req     (ext_req),
        .i_ext_addr    (ext_addr),
        .i_ext_we      (ext_we),
        .i_ext_wdata   (ext_wdata),
        .i_ext_mask    (ext_mask),
        .i_dmem_req    (dmem_req),
        .i_dmem_addr   (dmem_addr),
        .i_dmem_we     (dmem_we),
        .i_dmem_wdata  (dmem_wdata),
        .i_dmem_mask   (dmem_mask),
        .i_imem_req    (imem_req),
        .i_imem_addr   (imem_addr),
        .o_ext_gnt     (fx_ext_gnt),
        .o_dmem_gnt    (fx_dmem_gnt),
        .o_imem_gnt    (fx_imem_gnt),
        .o_ext_rvalid  (fx_ext_rv),
        .o_dmem_rvalid (fx_dmem_rv),
        .o_imem_rvalid (fx_imem_rv),
        .o_rdata       (fx_rdata),
        .o_ram_addr    (fx_ram_addr),
        .o_ram_wdata   (fx_ram_wdata),
        .o_ram_we      (fx_ram_we),
        .o_ram_mask    (fx_ram_mask),
        .i_ram_rdata   (ram_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .o_conflict_cnt  (fx_conflict_cnt),
        .o_imem_wait_cnt (fx_imem_wait_cnt)
`endif
    );

    // Behavioural RAM: preloaded while reset is low, masked writes, 1-cycle read.
    logic [DATA_W-1:0] mem [256];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'hA000_0000 + 32'(i);
            end
            mem[16] <= 32'h1234_5678;
        end else if (ram_we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (ram_mask[b]) begin
                    mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
        ram_rdata <= mem[ram_addr[7:0]];
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [2:0]        rr_seq   [3];
    logic [DATA_W-1:0] rr_data  [3];
    logic [2:0]        exp_fx;
    logic [2:0]        prev_fx;

    initial begin
        rr_seq[0]  = 3'b001;
        rr_seq[1]  = 3'b010;
        rr_seq[2]  = 3'b100;
        rr_data[0] = 32'hA000_0001;
        rr_data[1] = 32'hA000_0002;
        rr_data[2] = 32'hA000_0003;

        rst_n      = 1'b0;
        ext_req    = 1'b1;
        dmem_req   = 1'b1;
        imem_req   = 1'b1;
        ext_addr   = 30'd1;
        dmem_addr  = 30'd2;
        imem_addr  = 30'd3;
        ext_we     = 1'b0;
        dmem_we    = 1'b0;
        ext_wdata  = '0;
        dmem_wdata = '0;
        ext_mask   = '1;
        dmem_mask  = '1;

        // Reset: requests present but no grant, no rvalid.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt_rr", 64'(rr_gnt), 64'(3'b000));
        chk("rst_gnt_fx", 64'(fx_gnt), 64'(3'b000));
        chk("rst_rvalid", 64'(rr_rv), 64'(3'b000));
        chk("rst_ram_we", 64'(ram_we), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all three requesting: EXT, DMEM, IMEM, EXT, ...
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_gnt", 64'(rr_gnt), 64'(rr_seq[k % 3]));
            if (k > 0) begin
                chk("rr_rvalid", 64'(rr_rv), 64'(rr_seq[(k - 1) % 3]));
                chk("rr_rdata", 64'(rr_rdata), 64'(rr_data[(k - 1) % 3]));
            end
            @(negedge clk);
        end
        ext_req  = 1'b0;
        dmem_req = 1'b0;
        imem_req = 1'b0;
        #1;
        chk("rr_rvalid_last", 64'(rr_rv), 64'(3'b100));
        chk("rr_rdata_last", 64'(rr_rdata), 64'(32'hA000_0003));
        chk("idle_gnt", 64'(rr_gnt), 64'(3'b000));
        chk("idle_we", 64'(ram_we), 64'(1'b0));

        // Masked DMEM write, then IMEM read of the same word.
        @(negedge clk);
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = 30'h10;
        dmem_wdata = 32'hDEAD_BEEF;
        dmem_mask  = 4'b0011;
        #1;
        chk("wr_gnt", 64'(rr_gnt), 64'(3'b010));
        chk("wr_ram_we", 64'(ram_we), 64'(1'b1));
        chk("wr_ram_mask", 64'(ram_mask), 64'(4'b0011));
        chk("wr_ram_addr", 64'(ram_addr), 64'(30'h10));
        chk("wr_ram_wdata", 64'(ram_wdata), 64'(32'hDEAD_BEEF));
        @(negedge clk);
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_mask = '1;
        imem_req  = 1'b1;
        imem_addr = 30'h10;
        #1;
        chk("wr_no_rvalid", 64'(rr_rv), 64'(3'b000));
        chk("rd_gnt_imem", 64'(rr_gnt), 64'(3'b100));
        chk("rd_ram_mask", 64'(ram_mask), 64'(4'b1111));
        chk("rd_ram_we", 64'(ram_we), 64'(1'b0));
        @(negedge clk);
        imem_req = 1'b0;
        #1;
        chk("rd_imem_rvalid", 64'(rr_rv), 64'(3'b100));
        chk("rd_merged_word", 64'(rr_rdata), 64'(32'h1234_BEEF));

        // Streaming DMEM reads 0..7, one per cycle.
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            dmem_req  = 1'b1;
            dmem_addr = 30'(k);
            #1;
            chk("stream_gnt", 64'(rr_gnt), 64'(3'b010));
            if (k > 0) begin
                chk("stream_rvalid", 64'(rr_rv), 64'(3'b010));
                chk("stream_rdata", 64'(rr_rdata), 64'(32'hA000_0000 + 32'(k - 1)));
            end
            @(negedge clk);
        end
        dmem_req = 1'b0;
        #1;
        chk("stream_rvalid_last", 64'(rr_rv), 64'(3'b010));
        chk("stream_rdata_last", 64'(rr_rdata), 64'(32'hA000_0007));

        // Fixed priority with aging: EXT and IMEM both requesting.
        @(negedge clk);
        @(negedge clk);
        ext_req   = 1'b1;
        imem_req  = 1'b1;
        ext_addr  = 30'd1;
        imem_addr = 30'd3;
        prev_fx   = 3'b000;
        for (int k = 0; k < 10; k++) begin
            exp_fx = (k == 4 || k == 9) ? 3'b100 : 3'b001;
            #1;
            chk("fx_gnt", 64'(fx_gnt), 64'(exp_fx));
            chk("fx_rvalid", 64'(fx_rv), 64'(prev_fx));
            chk("fx_ram_addr", 64'(fx_ram_addr), 64'((k == 4 || k == 9) ? 30'd3 : 30'd1));
            chk("fx_ram_we", 64'(fx_ram_we), 64'(1'b0));
            prev_fx = exp_fx;
            @(negedge clk);
        end
        ext_req  = 1'b0;
        imem_req = 1'b0;
        #1;
        chk("fx_rvalid_last", 64'(fx_rv), 64'(3'b100));
        chk("fx_idle_gnt", 64'(fx_gnt), 64'(3'b000));

`ifdef MEM_ARB_PERF_EN
        // Ten cycles of DMEM+IMEM contention in round-robin.
        @(negedge clk);
        c0       = rr_conflict_cnt;
        w0       = rr_imem_wait_cnt;
        dmem_req = 1'b1;
        imem_req = 1'b1;
        repeat (10) @(negedge clk);
        dmem_req = 1'b0;
        imem_req = 1'b0;
        #1;
        chk("perf_conflict", 64'(rr_conflict_cnt - c0), 64'(32'd10));
        chk("perf_imem_wait", 64'(rr_imem_wait_cnt - w0), 64'(32'd5));
`endif

        // Read granted, then reset pulsed before the return edge.
        @(negedge clk);
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 30'd5;
        #1;
        chk("rst_pulse_gnt", 64'(rr_gnt), 64'(3'b010));
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        dmem_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pulse_no_rvalid", 64'(rr_rv), 64'(3'b000));
        ext_req  = 1'b1;
        dmem_req = 1'b1;
        imem_req = 1'b1;
        ext_addr = 30'd1;
        #1;
        chk("rst_pulse_gnt_forced0", 64'(rr_gnt), 64'(3'b000));
        rst_n = 1'b1;
        #1;
        chk("rst_release_gnt_ext", 64'(rr_gnt), 64'(3'b001));
        chk("rst_release_no_rvalid", 64'(rr_rv), 64'(3'b000));
        @(negedge clk);
        ext_req  = 1'b0;
        dmem_req = 1'b0;
        imem_req = 1'b0;
        #1;
        chk("rst_release_rvalid", 64'(rr_rv), 64'(3'b001));
        chk("rst_release_rdata", 64'(rr_rdata), 64'(32'hA000_0001));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
